// File: rtl/neuron_mac_sequencer.sv
// Time-multiplexed dense-layer scheduler: one FP32 multiplier and adder shared by all
// neurons; serial dot product + bias + ReLU per node. Optional macro NSEQ_OUT_READY_EN adds out_ready.
module neuron_mac_sequencer #(
    parameter int NUM_IN    = 15,
    parameter int NUM_NODES = 32,
    parameter int AAW       = 4,
    parameter int WAW       = 9,
    parameter int OAW       = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic [AAW-1:0] act_addr,
    input  logic [31:0]    act_data,
    output logic [WAW-1:0] w_addr,
    input  logic [31:0]    w_data,
    output logic           out_valid,
    output logic [OAW-1:0] out_addr,
    output logic [31:0]    out_data
`ifdef NSEQ_OUT_READY_EN
    ,
    input  logic           out_ready
`endif
);

    localparam int IW = $clog2(NUM_IN + 1);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [IW-1:0]  i_q, i_d;
    logic [OAW-1:0] node_q, node_d;
    logic [WAW-1:0] waddr_q, waddr_d;
    logic           tv_q, tv_d;
    logic           tfirst_q, tfirst_d;
    logic           tbias_q, tbias_d;
    logic [31:0]    acc_q, acc_d;
    logic [31:0]    out_q, out_d;

    logic           last_term, last_node, wr_fire, start_ok;
    logic [31:0]    prod_w, addend_w, acc_in_w, sum_w;

    // IEEE-754 single multiply, round-to-nearest-even; subnormals flushed to zero.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic              s, an, bn, ai, bi, az, bz, g, st;
        logic signed [9:0] e;
        logic [47:0]       p;
        logic [22:0]       frac;
        logic [23:0]       r;
        logic [31:0]       res;
        s  = a[31] ^ b[31];
        an = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        bn = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        ai = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        bi = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        az = (a[30:23] == 8'h00);
        bz = (b[30:23] == 8'h00);
        if (an || bn || (ai && bz) || (bi && az)) begin
            res = QNAN;
        end else if (ai || bi) begin
            res = {s, 8'hFF, 23'd0};
        end else if (az || bz) begin
            res = {s, 31'd0};
        end else begin
            e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
            p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
            if (p[47]) begin
                frac = p[46:24];
                g    = p[23];
                st   = |p[22:0];
                e    = e + 10'sd1;
            end else begin
                frac = p[45:23];
                g    = p[22];
                st   = |p[21:0];
            end
            r = {1'b0, frac} + {23'd0, g & (st | frac[0])};
            if (r[23]) e = e + 10'sd1;
            if (e >= 10'sd255)     res = {s, 8'hFF, 23'd0};
            else if (e <= 10'sd0)  res = {s, 31'd0};
            else                   res = {s, e[7:0], r[22:0]};
        end
        return res;
    endfunction

    // IEEE-754 single add, round-to-nearest-even; subnormals flushed to zero.
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        logic              an, bn, ai, bi, az, bz;
        logic [31:0]       x, y, res;
        logic [7:0]        d8;
        logic [4:0]        sh, lz;
        logic [50:0]       ext;
        logic [26:0]       big, sml, r;
        logic [27:0]       sum;
        logic [23:0]       m;
        logic signed [9:0] e;
        an = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        bn = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        ai = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        bi = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        az = (a[30:23] == 8'h00);
        bz = (b[30:23] == 8'h00);
        if (an || bn || (ai && bi && (a[31] != b[31]))) begin
            res = QNAN;
        end else if (ai) begin
            res = a;
        end else if (bi) begin
            res = b;
        end else if (az && bz) begin
            res = {a[31] & b[31], 31'd0};
        end else if (az) begin
            res = b;
        end else if (bz) begin
            res = a;
        end else begin
            if (a[30:0] >= b[30:0]) begin
                x = a;
                y = b;
            end else begin
                x = b;
                y = a;
            end
            d8  = x[30:23] - y[30:23];
            sh  = (d8 > 8'd27) ? 5'd27 : d8[4:0];
            ext = {1'b1, y[22:0], 27'd0} >> sh;
            sml = {ext[50:25], ext[24] | (|ext[23:0])};
            big = {1'b1, x[22:0], 3'b000};
            e   = $signed({2'b00, x[30:23]});
            if (x[31] == y[31]) begin
                sum = {1'b0, big} + {1'b0, sml};
                if (sum[27]) begin
                    r = {sum[27:2], sum[1] | sum[0]};
                    e = e + 10'sd1;
                end else begin
                    r = sum[26:0];
                end
            end else begin
                r  = big - sml;
                lz = 5'd0;
                for (int unsigned k = 0; k < 27; k++) begin
                    if (r[k]) lz = 5'd26 - 5'(k);
                end
                r = r << lz;
                e = e - $signed({5'd0, lz});
            end
            m = {1'b0, r[25:3]} + {23'd0, r[2] & (r[1] | r[0] | r[3])};
            if (m[23]) e = e + 10'sd1;
            if (r == 27'd0)        res = 32'd0;
            else if (e >= 10'sd255) res = {x[31], 8'hFF, 23'd0};
            else if (e <= 10'sd0)  res = {x[31], 31'd0};
            else                   res = {x[31], e[7:0], m[22:0]};
        end
        return res;
    endfunction

`ifdef NSEQ_OUT_READY_EN
    assign wr_fire = out_ready;
`else
    assign wr_fire = 1'b1;
`endif

    assign last_term = (i_q == IW'(NUM_IN));
    assign last_node = (node_q == OAW'(NUM_NODES - 1));
    assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    // Accumulate stage: one cycle behind ISSUE, operands straight from the memories.
    assign prod_w   = fmul(act_data, w_data);
    assign addend_w = tbias_q ? w_data : prod_w;
    assign acc_in_w = tfirst_q ? 32'd0 : acc_q;
    assign sum_w    = fadd(acc_in_w, addend_w);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ISSUE;
            S_ISSUE: if (last_term) state_d = S_DRAIN;
            S_DRAIN: state_d = S_WRITE;
            S_WRITE: if (wr_fire) state_d = last_node ? S_DONE : S_ISSUE;
            S_DONE:  state_d = start ? S_ISSUE : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN) || (state_q == S_WRITE);
        done      = (state_q == S_DONE);
        out_valid = (state_q == S_WRITE);
        act_addr  = ((state_q == S_ISSUE) && !last_term) ? AAW'(i_q) : '0;
    end

    assign w_addr   = waddr_q;
    assign out_addr = node_q;
    assign out_data = out_q;

    always_comb begin
        i_d      = i_q;
        node_d   = node_q;
        waddr_d  = waddr_q;
        tv_d     = 1'b0;
        tfirst_d = 1'b0;
        tbias_d  = 1'b0;
        acc_d    = acc_q;
        out_d    = out_q;
        if (start_ok) begin
            i_d     = '0;
            node_d  = '0;
            waddr_d = '0;
        end
        if (state_q == S_ISSUE) begin
            tv_d     = 1'b1;
            tfirst_d = (i_q == '0);
            tbias_d  = last_term;
            waddr_d  = waddr_q + WAW'(1);
            i_d      = last_term ? '0 : i_q + IW'(1);
        end
        if ((state_q == S_WRITE) && wr_fire) begin
            node_d = last_node ? '0 : node_q + OAW'(1);
        end
        if (tv_q) begin
            acc_d = sum_w;
            // Bias is always the final term, so its sum is the node result.
            if (tbias_q) out_d = sum_w[31] ? 32'd0 : sum_w;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q      <= '0;
            node_q   <= '0;
            waddr_q  <= '0;
            tv_q     <= 1'b0;
            tfirst_q <= 1'b0;
            tbias_q  <= 1'b0;
            acc_q    <= '0;
            out_q    <= '0;
        end else begin
            i_q      <= i_d;
            node_q   <= node_d;
            waddr_q  <= waddr_d;
            tv_q     <= tv_d;
            tfirst_q <= tfirst_d;
            tbias_q  <= tbias_d;
            acc_q    <= acc_d;
            out_q    <= out_d;
        end
    end

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Scoreboard bench for neuron_mac_sequencer: exact fixed-point reference model,
// synchronous memory models, and an independent output monitor.
module tb_neuron_mac_sequencer;

    localparam int NI  = 2;
    localparam int NN  = 2;
    localparam int AAW = 4;
    localparam int WAW = 9;
    localparam int OAW = 5;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           busy, done, out_valid;
    logic [AAW-1:0] act_addr;
    logic [WAW-1:0] w_addr;
    logic [OAW-1:0] out_addr;
    logic [31:0]    act_data, w_data, out_data;
`ifdef NSEQ_OUT_READY_EN
    logic           out_ready = 1'b1;
`endif

    neuron_mac_sequencer #(
        .NUM_IN(NI), .NUM_NODES(NN), .AAW(AAW), .WAW(WAW), .OAW(OAW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .act_addr(act_addr), .act_data(act_data), .w_addr(w_addr), .w_data(w_data),
        .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data)
`ifdef NSEQ_OUT_READY_EN
        , .out_ready(out_ready)
`endif
    );

    always #5 clk = ~clk;

    // Activations and weights in units of 1/4, biases in units of 1/16: every sum is exact.
    int          act_v [NI];
    int          w_v   [NN*(NI+1)];
    logic [31:0] act_mem [16];
    logic [31:0] w_mem   [512];

    always @(posedge clk) begin
        act_data <= act_mem[act_addr];
        w_data   <= w_mem[w_addr];
    end

    typedef struct {
        int          addr;
        logic [31:0] data;
    } exp_t;
    exp_t q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] to_f32(input int v, input int frac_bits);
        int          mag, p;
        logic [31:0] m;
        if (v == 0) return 32'd0;
        mag = (v < 0) ? -v : v;
        p   = 0;
        for (int k = 0; k < 31; k++) if (mag[k]) p = k;
        m = 32'(mag) << (23 - p);
        return {v < 0, 8'(p - frac_bits + 127), m[22:0]};
    endfunction

    task automatic load_mem();
        for (int i = 0; i < NI; i++) act_mem[i] = to_f32(act_v[i], 2);
        for (int n = 0; n < NN; n++) begin
            for (int i = 0; i < NI; i++) w_mem[n*(NI+1)+i] = to_f32(w_v[n*(NI+1)+i], 2);
            w_mem[n*(NI+1)+NI] = to_f32(w_v[n*(NI+1)+NI], 4);
        end
    endtask

    task automatic randomize_layer();
        for (int i = 0; i < NI; i++) act_v[i] = int'($urandom_range(30)) - 15;
        for (int n = 0; n < NN; n++) begin
            for (int i = 0; i < NI; i++) w_v[n*(NI+1)+i] = int'($urandom_range(30)) - 15;
            w_v[n*(NI+1)+NI] = int'($urandom_range(126)) - 63;
        end
        load_mem();
    endtask

    task automatic push_expected();
        int s;
        for (int n = 0; n < NN; n++) begin
            s = w_v[n*(NI+1)+NI];
            for (int i = 0; i < NI; i++) s += act_v[i] * w_v[n*(NI+1)+i];
            q.push_back('{n, (s > 0) ? to_f32(s, 4) : 32'd0});
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 2000 && !seen; k++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: timeout waiting for done", name);
        end
    endtask

    task automatic run_pass(input string name);
        push_expected();
        pulse_start();
        wait_done(name);
    endtask

    // Monitor: scoreboard pop, per-node cycle count, done pulse, stall stability.
    int          cyc = 0, stalls = 0;
    bit          exp_done = 1'b0, held_v = 1'b0, fire;
    logic [37:0] held;
    exp_t        e;

    always @(negedge clk) begin
        if (!rst_n) begin
            cyc = 0; stalls = 0; exp_done = 1'b0; held_v = 1'b0;
        end else begin
            check("done", done, exp_done);
            if (done) check("busy_in_done", busy, 0);
            exp_done = 1'b0;
            if (busy) cyc++;
            if (held_v) begin
                check("stall_hold", {out_valid, out_addr, out_data}, held);
                held_v = 1'b0;
            end
            if (out_valid) begin
`ifdef NSEQ_OUT_READY_EN
                fire = out_ready;
`else
                fire = 1'b1;
`endif
                if (!fire) begin
                    stalls++;
                    held   = {1'b1, out_addr, out_data};
                    held_v = 1'b1;
                    check("busy_stall", busy, 1);
                end else begin
                    if (q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_write: got addr %0d data %h, expected no write", out_addr, out_data);
                    end else begin
                        e = q.pop_front();
                        check("out_addr", 64'(out_addr), 64'(e.addr));
                        check("out_data", 64'(out_data), 64'(e.data));
                        exp_done = (e.addr == NN - 1);
                    end
                    check("node_cycles", 64'(cyc), 64'(NI + 3 + stalls));
                    cyc = 0;
                    stalls = 0;
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 16; k++) act_mem[k] = 32'd0;
        for (int k = 0; k < 512; k++) w_mem[k] = 32'd0;
        repeat (2) @(posedge clk);
        #1 check("reset_outputs", {busy, done, out_valid, act_addr, w_addr, out_addr, out_data}, 0);
        rst_n = 1'b1;

        // T1/T2: 1*0.5 + 2*0.25 + 1 = 2.0 on node 0; node 1 negative clamps to 0.
        act_v = '{4, 8};
        w_v   = '{2, 1, 16, -4, 0, 0};
        load_mem();
        run_pass("t1_t2");

        // T3: zero weights with a -0.0 bias.
        act_v = '{5, -3};
        w_v   = '{0, 0, 0, 0, 0, 0};
        load_mem();
        w_mem[NI]        = 32'h8000_0000;
        w_mem[2*NI + 1]  = 32'h8000_0000;
        run_pass("t3");

        // T4: mid-layer start is ignored; start in the DONE cycle chains a pass.
        randomize_layer();
        push_expected();
        pulse_start();
        repeat (2) @(posedge clk);
        #1 check("busy_mid", busy, 1);
        pulse_start();
        wait_done("t4_first");
        push_expected();
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("busy_after_done_start", busy, 1);
        wait_done("t4_second");
        repeat (10) @(posedge clk);
        #1 check("no_extra_writes", 64'(q.size()), 0);
        check("idle_after_t4", busy, 0);

        // T5: asynchronous reset during node 0 ISSUE aborts the pass.
        randomize_layer();
        pulse_start();
        rst_n = 1'b0;
        #1 check("reset_mid_outputs", {busy, done, out_valid, act_addr, w_addr, out_addr, out_data}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_pass("t5_clean");

        for (int p = 0; p < 20; p++) begin
            randomize_layer();
            run_pass("random");
        end

`ifdef NSEQ_OUT_READY_EN
        // T6: hold out_ready low for four WRITE cycles on node 0.
        randomize_layer();
        out_ready = 1'b0;
        push_expected();
        pulse_start();
        for (int k = 0; k < 50 && !out_valid; k++) begin
            @(posedge clk); #1;
        end
        check("t6_write_seen", out_valid, 1);
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
        wait_done("t6");
`endif

        repeat (3) @(posedge clk);
        #1 check("queue_empty", 64'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
